// File: rtl/uart_tx_if.sv
// Host-side handshake for the UART transmitter: parallel word plus valid/ready.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Every output is a register loaded from the next-state values, so the line moves on the accept edge.
module uart_tx #(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE     = 115200,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1
) (
    input  logic     clk,
    input  logic     reset,
    uart_tx_if.slave host,
    output logic     tx_serial,
    output logic     tx_busy,
    output logic     tx_done
);
    localparam int BAUD_DIVIDER = CLK_FREQUENCY / BAUD_RATE;
    localparam int CNT_W        = (BAUD_DIVIDER > 2) ? $clog2(BAUD_DIVIDER) : 1;
    localparam int BIT_W        = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(BAUD_DIVIDER - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic             ODD       = (PARITY == 1);

    if (BAUD_DIVIDER < 2) begin : g_bad_divider
        $fatal(1, "uart_tx: CLK_FREQUENCY/BAUD_RATE must be at least 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $fatal(1, "uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $fatal(1, "uart_tx: STOP_BITS must be 1 or 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $fatal(1, "uart_tx: DATA_BITS must be 5..9");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     div_reg, div_next;
    logic [BIT_W-1:0]     bit_reg, bit_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 parity_reg, parity_next;
    logic                 serial_reg, serial_next;
    logic                 ready_reg, ready_next;
    logic                 busy_reg;
    logic                 done_reg, done_next;
    logic                 bit_end;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= S_IDLE;
            div_reg    <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            serial_reg <= 1'b1;
            ready_reg  <= 1'b1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            div_reg    <= div_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            parity_reg <= parity_next;
            serial_reg <= serial_next;
            ready_reg  <= ready_next;
            busy_reg   <= !ready_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        div_next    = div_reg;
        bit_next    = bit_reg;
        shift_next  = shift_reg;
        parity_next = parity_reg;
        bit_end     = (div_reg == DIV_LAST);

        if (state_reg != S_IDLE) begin
            div_next = bit_end ? '0 : div_reg + 1'b1;
        end

        case (state_reg)
            S_IDLE: begin
                if (host.tx_valid && ready_reg) begin
                    state_next  = S_START;
                    shift_next  = host.tx_data;
                    parity_next = (^host.tx_data) ^ ODD;
                    div_next    = '0;
                    bit_next    = '0;
                end
            end
            S_START: begin
                if (bit_end) state_next = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    if (bit_reg == DATA_LAST) begin
                        bit_next   = '0;
                        state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) state_next = S_STOP;
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_reg == STOP_LAST) begin
                        bit_next   = '0;
                        state_next = S_IDLE;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase

        // Output registers are loaded from the state being entered.
        case (state_next)
            S_START:  serial_next = 1'b0;
            S_DATA:   serial_next = shift_next[0];
            S_PARITY: serial_next = parity_next;
            default:  serial_next = 1'b1;
        endcase
        ready_next = (state_next == S_IDLE);
        done_next  = (state_next == S_STOP) && (bit_next == STOP_LAST) && (div_next == DIV_LAST);
    end

    assign host.tx_ready = ready_reg;
    assign tx_serial     = serial_reg;
    assign tx_busy       = busy_reg;
    assign tx_done       = done_reg;
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances (no parity, even, odd, two stop bits), divider 10.
module tb_uart_tx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_drv = 8'h00;
    logic       valid_drv = 1'b0;
    logic [1:0] sel = 2'd0;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    wire [3:0] ser_v, busy_v, done_v, ready_v;
    wire       ser_m   = ser_v[sel];
    wire       busy_m  = busy_v[sel];
    wire       done_m  = done_v[sel];
    wire       ready_m = ready_v[sel];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0: no parity; 1: even; 2: odd; 3: two stop bits.
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        uart_tx_if #(.DATA_BITS(8)) bus ();
        assign bus.tx_data  = data_drv;
        assign bus.tx_valid = valid_drv && (sel == gi);
        assign ready_v[gi]  = bus.tx_ready;

        uart_tx #(
            .CLK_FREQUENCY(1000),
            .BAUD_RATE    (100),
            .DATA_BITS    (8),
            .PARITY       ((gi == 1) ? 2 : ((gi == 2) ? 1 : 0)),
            .STOP_BITS    ((gi == 3) ? 2 : 1)
        ) dut (
            .clk      (clk),
            .reset    (rst_n),
            .host     (bus.slave),
            .tx_serial(ser_v[gi]),
            .tx_busy  (busy_v[gi]),
            .tx_done  (done_v[gi])
        );
    end

    // Waits (bounded) for ready, then presents d for one accept edge.
    task automatic start_tx(input logic [7:0] d, input bit hold);
        int n = 0;
        while (ready_m !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            $display("FAIL ready_timeout got ready=%b exp 1", ready_m);
            errors++;
        end
        @(posedge clk);
        #1 data_drv = d;
        valid_drv = 1'b1;
        @(posedge clk);
        #1 if (!hold) valid_drv = 1'b0;
    endtask

    // Records the line level per bit slot, instability inside slots, busy/ready
    // anomalies and tx_done positions; optionally pokes a request mid-frame.
    task automatic capture(input int nslots, input int disturb_at,
                           output logic [15:0] lv, output int unstable,
                           output int bad_hs, output int done_at,
                           output int done_cnt, output int start_cyc);
        int k;
        lv = '0; unstable = 0; bad_hs = 0; done_at = -1; done_cnt = 0; start_cyc = 0;
        for (int s = 0; s < nslots; s++) begin
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                k = s * 10 + c;
                if (k == 0) start_cyc = cyc;
                if (c == 0) lv[s] = ser_m;
                else if (ser_m !== lv[s]) unstable++;
                if (busy_m !== 1'b1 || ready_m !== 1'b0) bad_hs++;
                if (done_m === 1'b1) begin
                    done_cnt++;
                    if (done_at < 0) done_at = k;
                end
                if (k == disturb_at) begin
                    data_drv  = 8'hFF;
                    valid_drv = 1'b1;
                end
                if (k == disturb_at + 1) valid_drv = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ser_v !== 4'hF || ready_v !== 4'hF || busy_v !== 4'h0 || done_v !== 4'h0) begin
            $display("FAIL reset_outputs got ser=%b rdy=%b busy=%b done=%b exp F F 0 0",
                     ser_v, ready_v, busy_v, done_v);
            errors++;
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (ser_v !== 4'hF || ready_v !== 4'hF || busy_v !== 4'h0) begin
            $display("FAIL idle_after_reset got ser=%b rdy=%b busy=%b exp F F 0", ser_v, ready_v, busy_v);
            errors++;
        end
    endtask

    task automatic test_basic;
        logic [15:0] lv;
        int unst, bad, dat, dcnt, sc;
        sel = 2'd0;
        start_tx(8'hA5, 1'b0);
        capture(10, -5, lv, unst, bad, dat, dcnt, sc);
        // A5 LSB first: 0,1,0,1,0,0,1,0,1,1
        checks++;
        if (lv[9:0] !== 10'h34A) begin
            $display("FAIL basic_bits got %h exp 34a", lv[9:0]); errors++;
        end
        checks++;
        if (unst !== 0) begin $display("FAIL basic_bit_width got %0d exp 0", unst); errors++; end
        checks++;
        if (bad !== 0) begin $display("FAIL basic_busy got %0d exp 0", bad); errors++; end
        checks++;
        if (dat !== 99 || dcnt !== 1) begin
            $display("FAIL basic_done got at=%0d cnt=%0d exp at=99 cnt=1", dat, dcnt); errors++;
        end
        @(negedge clk);
        checks++;
        if (ready_m !== 1'b1 || busy_m !== 1'b0 || done_m !== 1'b0 || ser_m !== 1'b1) begin
            $display("FAIL basic_idle got rdy=%b busy=%b done=%b ser=%b exp 1 0 0 1",
                     ready_m, busy_m, done_m, ser_m);
            errors++;
        end
    endtask

    task automatic test_parity;
        logic [15:0] lv;
        int unst, bad, dat, dcnt, sc;
        sel = 2'd1;
        start_tx(8'h07, 1'b0);
        capture(11, -5, lv, unst, bad, dat, dcnt, sc);
        checks++;
        if (lv[10:0] !== 11'h60E || unst !== 0) begin
            $display("FAIL even_parity got %h unst=%0d exp 60e unst=0", lv[10:0], unst); errors++;
        end
        checks++;
        if (dat !== 109 || dcnt !== 1) begin
            $display("FAIL even_done got at=%0d cnt=%0d exp 109 1", dat, dcnt); errors++;
        end
        sel = 2'd2;
        start_tx(8'h07, 1'b0);
        capture(11, -5, lv, unst, bad, dat, dcnt, sc);
        checks++;
        if (lv[10:0] !== 11'h40E || unst !== 0) begin
            $display("FAIL odd_parity got %h unst=%0d exp 40e unst=0", lv[10:0], unst); errors++;
        end
        checks++;
        if (dat !== 109 || dcnt !== 1 || bad !== 0) begin
            $display("FAIL odd_done got at=%0d cnt=%0d bad=%0d exp 109 1 0", dat, dcnt, bad); errors++;
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] lv1, lv2;
        int unst1, unst2, bad, dat1, dat2, dcnt, sc1, sc2;
        sel = 2'd0;
        start_tx(8'h55, 1'b1);
        data_drv = 8'hAA;
        capture(10, -5, lv1, unst1, bad, dat1, dcnt, sc1);
        @(negedge clk);
        checks++;
        if (ser_m !== 1'b1 || ready_m !== 1'b1) begin
            $display("FAIL b2b_gap got ser=%b rdy=%b exp 1 1", ser_m, ready_m); errors++;
        end
        @(posedge clk);
        #1 valid_drv = 1'b0;
        capture(10, -5, lv2, unst2, bad, dat2, dcnt, sc2);
        checks++;
        if (lv1[9:0] !== 10'h2AA || unst1 !== 0) begin
            $display("FAIL b2b_first got %h unst=%0d exp 2aa 0", lv1[9:0], unst1); errors++;
        end
        checks++;
        if (lv2[9:0] !== 10'h354 || unst2 !== 0) begin
            $display("FAIL b2b_second got %h unst=%0d exp 354 0", lv2[9:0], unst2); errors++;
        end
        checks++;
        if (sc2 - sc1 !== 101) begin
            $display("FAIL b2b_spacing got %0d exp 101", sc2 - sc1); errors++;
        end
        checks++;
        if (dat1 !== 99 || dat2 !== 99) begin
            $display("FAIL b2b_done got %0d %0d exp 99 99", dat1, dat2); errors++;
        end
    endtask

    task automatic test_ignore_midframe;
        logic [15:0] lv;
        int unst, bad, dat, dcnt, sc, extra;
        sel = 2'd0;
        start_tx(8'h81, 1'b0);
        capture(10, 35, lv, unst, bad, dat, dcnt, sc);
        checks++;
        if (lv[9:0] !== 10'h302 || unst !== 0) begin
            $display("FAIL midframe_bits got %h unst=%0d exp 302 0", lv[9:0], unst); errors++;
        end
        checks++;
        if (dcnt !== 1 || dat !== 99) begin
            $display("FAIL midframe_done got cnt=%0d at=%0d exp 1 99", dcnt, dat); errors++;
        end
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (ser_m !== 1'b1 || done_m !== 1'b0 || ready_m !== 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            $display("FAIL midframe_dropped got %0d active clocks exp 0", extra); errors++;
        end
    endtask

    task automatic test_reset_midframe;
        logic [15:0] lv;
        int unst, bad, dat, dcnt, sc, dn;
        sel = 2'd0;
        start_tx(8'hA5, 1'b0);
        repeat (45) @(negedge clk);
        checks++;
        if (ser_m !== 1'b0) begin
            $display("FAIL rst_mid_pre got %b exp 0", ser_m); errors++;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ser_m !== 1'b1 || ready_m !== 1'b1 || busy_m !== 1'b0 || done_m !== 1'b0) begin
            $display("FAIL rst_mid_async got ser=%b rdy=%b busy=%b done=%b exp 1 1 0 0",
                     ser_m, ready_m, busy_m, done_m);
            errors++;
        end
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_m !== 1'b0) dn++;
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done_m !== 1'b0) dn++;
        end
        checks++;
        if (dn !== 0) begin $display("FAIL rst_mid_nodone got %0d exp 0", dn); errors++; end
        start_tx(8'h3C, 1'b0);
        capture(10, -5, lv, unst, bad, dat, dcnt, sc);
        checks++;
        if (lv[9:0] !== 10'h278 || unst !== 0 || dat !== 99) begin
            $display("FAIL rst_mid_after got %h unst=%0d done_at=%0d exp 278 0 99", lv[9:0], unst, dat);
            errors++;
        end
    endtask

    task automatic test_two_stop;
        logic [15:0] lv;
        int unst, bad, dat, dcnt, sc;
        sel = 2'd3;
        start_tx(8'hA5, 1'b0);
        capture(11, -5, lv, unst, bad, dat, dcnt, sc);
        checks++;
        if (lv[10:0] !== 11'h74A || unst !== 0 || bad !== 0) begin
            $display("FAIL two_stop_bits got %h unst=%0d bad=%0d exp 74a 0 0", lv[10:0], unst, bad); errors++;
        end
        checks++;
        if (dat !== 109 || dcnt !== 1) begin
            $display("FAIL two_stop_done got at=%0d cnt=%0d exp 109 1", dat, dcnt); errors++;
        end
        @(negedge clk);
        checks++;
        if (ready_m !== 1'b1 || busy_m !== 1'b0) begin
            $display("FAIL two_stop_idle got rdy=%b busy=%b exp 1 0", ready_m, busy_m); errors++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_ignore_midframe();
        test_reset_midframe();
        test_two_stop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got time=%0t exp test end", $time);
        $fatal(1, "timeout");
    end
endmodule
